// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped input capture block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_pkg;

    // Bank width and the folded change-flag width per bank
    localparam int IO_W    = 32;
    localparam int IO_HALF = 16;

    // Register offsets, selected by rd_addr[3:2]
    localparam logic [1:0] IO_OFS_SW    = 2'd0;
    localparam logic [1:0] IO_OFS_PORT  = 2'd1;
    localparam logic [1:0] IO_OFS_FLAGS = 2'd2;
    localparam logic [1:0] IO_OFS_CNT   = 2'd3;

    // Sticky change flags as seen in the flags register (port in the upper half)
    typedef struct packed {
        logic [IO_HALF-1:0] port_chg;
        logic [IO_HALF-1:0] sw_chg;
    } io_flags_t;

    // Fold a 32-bit delta into 16 flag bits: bit i covers inputs i and i+16
    function automatic logic [IO_HALF-1:0] io_fold(input logic [IO_W-1:0] v);
        return v[IO_W-1:IO_HALF] | v[IO_HALF-1:0];
    endfunction

endpackage

// File: rtl/io_debounce_bank.sv
// Synchroniser + debouncer for one 32-bit raw input bank.
// Latency: a held raw change lands in stable SYNC_STAGES+DEBOUNCE_CYCLES edges after the first sampling edge.
// Backpressure: none; delta is a single-cycle pulse that the consumer must take on the update edge.
//
// Ports:
//   clk_i   core clock
//   rst_n   asynchronous active-low reset
//   raw     asynchronous input bits
//   stable  last accepted (debounced) bank value
//   delta   stable ^ synced on the edge where stable updates, zero otherwise
module io_debounce_bank
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic [IO_W-1:0] raw,
    output logic [IO_W-1:0] stable,
    output logic [IO_W-1:0] delta
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [IO_W-1:0] sync_q [SYNC_STAGES];
    logic [IO_W-1:0] synced;
    logic [IO_W-1:0] synced_prev;
    logic [DB_W-1:0] db_cnt;
    logic            settled;
    logic            accept;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Counting only runs while the synced value holds still and differs from
    // what is already accepted; any movement restarts the window.
    assign settled = (synced == synced_prev) && (synced != stable);
    assign accept  = settled && (db_cnt == DB_LAST);
    assign delta   = accept ? (stable ^ synced) : '0;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            synced_prev <= '0;
            stable      <= '0;
            db_cnt      <= '0;
        end else begin
            synced_prev <= synced;
            if (accept) begin
                stable <= synced;
                db_cnt <= '0;
            end else if (settled) begin
                db_cnt <= db_cnt + DB_W'(1);
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/io_input_capture.sv
// Memory-mapped switch/port input peripheral with sticky change flags, event counter and change irq.
// Latency: read data and rd_valid_o one cycle after rd_req_i; irq_o one cycle after a flag changes.
// Backpressure: none; a read may be accepted every cycle and its response is always returned next cycle.
//
// Ports:
//   clk_i / rst_n     core clock, asynchronous active-low reset (release expected synchronous to clk_i)
//   input_switch_i    raw switch bank
//   input_port_i      raw input port
//   rd_req_i          read strobe, one word per cycle
//   rd_addr_i         byte offset; [3:2] picks switch / port / flags (read-to-clear) / event counter
//   rd_data_o         read data, held between responses
//   rd_valid_o        read response strobe
//   irq_o             registered OR of all change flags
module io_input_capture
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 32
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic [IO_W-1:0] input_switch_i,
    input  logic [IO_W-1:0] input_port_i,
    input  logic            rd_req_i,
    input  logic [3:0]      rd_addr_i,
    output logic [IO_W-1:0] rd_data_o,
    output logic            rd_valid_o,
    output logic            irq_o
);

    logic [IO_W-1:0]  sw_stable;
    logic [IO_W-1:0]  sw_delta;
    logic [IO_W-1:0]  port_stable;
    logic [IO_W-1:0]  port_delta;

    io_flags_t        flags_q;
    io_flags_t        flags_set;
    io_flags_t        flags_nxt;
    logic             flags_clr;
    logic             bank_upd;
    logic [CNT_W-1:0] ev_cnt;

    logic [1:0]       rd_sel;
    logic [IO_W-1:0]  rd_mux;
    logic             addr_unused;

    io_debounce_bank #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_bank (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .raw    (input_switch_i),
        .stable (sw_stable),
        .delta  (sw_delta)
    );

    io_debounce_bank #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_port_bank (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .raw    (input_port_i),
        .stable (port_stable),
        .delta  (port_delta)
    );

    assign rd_sel      = rd_addr_i[3:2];
    assign addr_unused = ^rd_addr_i[1:0];

    // A flags read clears the old flags, but a delta landing on that same
    // edge is ORed in afterwards so it survives for the next read.
    assign flags_clr          = rd_req_i && (rd_sel == IO_OFS_FLAGS);
    assign flags_set.port_chg = io_fold(port_delta);
    assign flags_set.sw_chg   = io_fold(sw_delta);
    assign flags_nxt          = (flags_clr ? io_flags_t'('0) : flags_q) | flags_set;

    // One event per edge with any accepted update, even if both banks move.
    assign bank_upd = (|sw_delta) || (|port_delta);

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            IO_OFS_SW:    rd_mux = sw_stable;
            IO_OFS_PORT:  rd_mux = port_stable;
            IO_OFS_FLAGS: rd_mux = flags_q;
            IO_OFS_CNT:   rd_mux = IO_W'(ev_cnt);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            flags_q    <= '0;
            ev_cnt     <= '0;
            irq_o      <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            flags_q    <= flags_nxt;
            irq_o      <= |flags_q;
            rd_valid_o <= rd_req_i;
            if (bank_upd) begin
                ev_cnt <= ev_cnt + CNT_W'(1);
            end
            if (rd_req_i) begin
                rd_data_o <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_io_input_capture.sv
// Self-checking bench for io_input_capture: two instances (32-bit and 4-bit event counter)
// share stimulus; every read pushes its expected word to a queue that a negedge monitor pops.
// Table of bank patterns plus hand-written sequences for timing, glitch, read-clear race and reset.
module tb_io_input_capture;

    logic        clk_i;
    logic        rst_n;
    logic [31:0] input_switch_i;
    logic [31:0] input_port_i;
    logic        rd_req_i;
    logic [3:0]  rd_addr_i;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;
    logic [31:0] rd_data4;
    logic        rd_valid4;
    logic        irq4;

    io_input_capture u_dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .input_switch_i (input_switch_i),
        .input_port_i   (input_port_i),
        .rd_req_i       (rd_req_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .irq_o          (irq)
    );

    io_input_capture #(.CNT_W(4)) u_dut4 (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .input_switch_i (input_switch_i),
        .input_port_i   (input_port_i),
        .rd_req_i       (rd_req_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data4),
        .rd_valid_o     (rd_valid4),
        .irq_o          (irq4)
    );

    initial clk_i = 1'b0;
    always #20 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] d4;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        logic [31:0] sw;
        logic [31:0] port;
        logic [31:0] flags;
        int          inc;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input logic [31:0] exp4, input string nm);
        sb_t e;
        e.d    = exp;
        e.d4   = exp4;
        e.name = nm;
        sb_q.push_back(e);
        rd_req_i  = 1'b1;
        rd_addr_i = a;
        @(negedge clk_i);
        rd_req_i  = 1'b0;
    endtask

    // Response monitor: every response must match the oldest outstanding read
    always @(negedge clk_i) begin
        if (rd_valid || rd_valid4) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=valid expected=idle t=%0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_valid"}, {30'd0, rd_valid, rd_valid4}, 32'd3);
                chk(mon_e.name, rd_data, mon_e.d);
                chk({mon_e.name, "_cnt4"}, rd_data4, mon_e.d4);
            end
        end
    end

    int cnt;
    int hi_cnt;

    initial begin
        // bank pattern table: new sw, new port, expected folded flags, counter increment
        vt[0] = '{32'h5A00_0000, 32'h0000_FFFF, 32'hFFFF_5AA5, 1};
        vt[1] = '{32'h5A00_0000, 32'h8000_0000, 32'hFFFF_0000, 1};
        vt[2] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 1};
        vt[3] = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_FFFF, 1};
        vt[4] = '{32'h0001_0001, 32'h1234_0000, 32'h1234_FFFF, 1};
        vt[5] = '{32'h0001_0001, 32'h1234_0000, 32'h0000_0000, 0};
        vt[6] = '{32'h0001_0000, 32'h1234_0000, 32'h0000_0001, 1};

        rst_n          = 1'b0;
        input_switch_i = '0;
        input_port_i   = '0;
        rd_req_i       = 1'b0;
        rd_addr_i      = '0;
        cnt            = 0;

        // reset state
        #30;
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk_i);
        rd(4'h0, 32'h0, 32'h0, "rst_sw");
        rd(4'h4, 32'h0, 32'h0, "rst_port");
        rd(4'h8, 32'h0, 32'h0, "rst_flags");
        rd(4'hC, 32'h0, 32'h0, "rst_cnt");

        // glitch: port pulse for 2 cycles must be rejected
        repeat (4) @(negedge clk_i);
        input_port_i = 32'h1;
        repeat (2) @(negedge clk_i);
        input_port_i = 32'h0;
        hi_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            if (irq) hi_cnt++;
        end
        chk("glitch_irq_quiet", hi_cnt, 0);
        rd(4'h4, 32'h0, 32'h0, "glitch_port");
        rd(4'h8, 32'h0, 32'h0, "glitch_flags");
        rd(4'hC, 32'h0, 32'h0, "glitch_cnt");

        // switch 0 -> A5: stable and flags land 6 edges after the first sampling edge
        input_switch_i = 32'h0000_00A5;
        repeat (6) @(negedge clk_i);
        rd(4'h0, 32'h0, 32'h0, "sw_before_update");
        chk("irq_before_flag", {31'd0, irq}, 32'd0);
        rd(4'h0, 32'hA5, 32'hA5, "sw_after_update");
        chk("irq_after_flag", {31'd0, irq}, 32'd1);
        cnt = 1;
        // back-to-back flag reads: first returns and clears, second is empty
        rd(4'h8, 32'hA5, 32'hA5, "flags_first");
        chk("irq_during_clear", {31'd0, irq}, 32'd1);
        rd(4'h8, 32'h0, 32'h0, "flags_second");
        chk("irq_dropped", {31'd0, irq}, 32'd0);

        // port update on the same edge as a flags read: set wins, not returned
        input_port_i = 32'h0001_0000;
        repeat (6) @(negedge clk_i);
        rd(4'h8, 32'h0, 32'h0, "flags_race_first");
        rd(4'h8, 32'h0001_0000, 32'h0001_0000, "flags_race_second");
        rd(4'h5, 32'h0001_0000, 32'h0001_0000, "race_port");
        cnt = 2;

        // table-driven bank patterns, including a simultaneous dual-bank update
        for (int i = 0; i < 7; i++) begin
            input_switch_i = vt[i].sw;
            input_port_i   = vt[i].port;
            repeat (8) @(negedge clk_i);
            cnt += vt[i].inc;
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, (vt[i].flags != 0)});
            rd(4'h1, vt[i].sw, vt[i].sw, $sformatf("vec%0d_sw", i));
            rd(4'h6, vt[i].port, vt[i].port, $sformatf("vec%0d_port", i));
            rd(4'hA, vt[i].flags, vt[i].flags, $sformatf("vec%0d_flags", i));
            rd(4'hF, cnt, cnt & 15, $sformatf("vec%0d_cnt", i));
            chk($sformatf("vec%0d_irq_clr", i), {31'd0, irq}, 32'd0);
        end

        // nine more switch updates: 17 total, 4-bit counter wraps to 1
        for (int i = 0; i < 9; i++) begin
            input_switch_i = input_switch_i ^ 32'h8000_0000;
            repeat (8) @(negedge clk_i);
        end
        cnt += 9;
        rd(4'hC, cnt, cnt & 15, "cnt_wrap");
        rd(4'h0, 32'h8001_0000, 32'h8001_0000, "toggle_sw");
        chk("irq_pending", {31'd0, irq}, 32'd1);

        // reset mid-debounce with a read in flight and another requested
        input_switch_i = 32'h0000_00FF;
        repeat (3) @(negedge clk_i);
        begin
            sb_t e;
            e.d    = cnt;
            e.d4   = cnt & 15;
            e.name = "pre_reset_cnt";
            sb_q.push_back(e);
        end
        rd_req_i  = 1'b1;
        rd_addr_i = 4'hC;
        @(negedge clk_i);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rd_valid}, 32'd0);
        chk("arst_data", rd_data, 32'd0);
        chk("arst_data4", rd_data4, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        sb_q.delete();
        @(negedge clk_i);
        rd_req_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_rst_no_valid", {31'd0, rd_valid}, 32'd0);
        repeat (6) @(negedge clk_i);
        // non-zero inputs at release debounce normally, both banks on one edge
        rd(4'h8, 32'h1234_00FF, 32'h1234_00FF, "post_rst_flags");
        rd(4'h0, 32'h0000_00FF, 32'h0000_00FF, "post_rst_sw");
        rd(4'h4, 32'h1234_0000, 32'h1234_0000, "post_rst_port");
        rd(4'hC, 32'h1, 32'h1, "post_rst_cnt");

        repeat (3) @(negedge clk_i);
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
